// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller: drives a combinational ROM from a fetch PC and
// buffers {pc, inst} pairs in a small FIFO presented to decode.
module if_fetch_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        fetch_en,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] rom_a,
    input  logic [31:0] rom_inst,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [31:0]       pc_mem   [DEPTH];
    logic [31:0]       inst_mem [DEPTH];
    logic              run;
    logic              push;
    logic              pop;

    // fetch_en takes effect in the cycle it is sampled, so pushing is
    // qualified by the state being entered rather than the registered one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (fetch_en)  state_d = RUN;
            RUN:  if (!fetch_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        run = (state_d == RUN);
    end

    assign id_valid = (count_q != '0);
    assign pop      = id_valid && id_ready && !redirect;
    assign push     = run && !redirect && ((count_q != FULL_CNT) || pop);

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= pc_q;
            inst_mem[wr_ptr_q] <= rom_inst;
        end
    end

    assign rom_a   = pc_q;
    assign id_pc   = id_valid ? pc_mem[rd_ptr_q]   : 32'd0;
    assign id_inst = id_valid ? inst_mem[rd_ptr_q] : 32'd0;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed scenarios followed by random
// traffic, all compared against a queue-based behavioural model.
module tb_if_fetch_ctrl;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        clrn;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] rom_a;
    logic [31:0] rom_inst;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;

    if_fetch_ctrl #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .rom_a       (rom_a),
        .rom_inst    (rom_inst),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_inst     (id_inst),
        .id_pc       (id_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [5:0] idx;
        idx = a[7:2];
        if (idx == 6'd1) return 32'h14000C21;
        return 32'h1000_0000 + {26'd0, idx};
    endfunction

    assign rom_inst = rom_word(rom_a);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock edge of the reference behaviour, using the inputs as driven.
    task automatic model_step();
        int  n;
        bit  pop;
        bit  push;
        if (redirect) begin
            mq.delete();
            m_pc = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            n    = mq.size();
            pop  = (n > 0) && id_ready;
            push = fetch_en && ((n < DEPTH) || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back('{pc: m_pc, inst: rom_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic check_outputs();
        chk("id_valid", {31'd0, id_valid}, {31'd0, mq.size() != 0});
        chk("rom_a", rom_a, m_pc);
        if (mq.size() != 0) begin
            chk("id_pc", id_pc, mq[0].pc);
            chk("id_inst", id_inst, mq[0].inst);
        end
        $display("cyc t=%0t fe=%0b rd=%0b rdy=%0b rom_a=%08h v=%0b pc=%08h inst=%08h",
                 $time, fetch_en, redirect, id_ready, rom_a, id_valid, id_pc, id_inst);
    endtask

    task automatic cycle(input logic fe, input logic rd, input logic [31:0] rpc, input logic rdy);
        fetch_en    = fe;
        redirect    = rd;
        redirect_pc = rpc;
        id_ready    = rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        clrn        = 1'b0;
        fetch_en    = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        id_ready    = 1'b1;
        m_pc        = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_rom_a", rom_a, 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_inst", id_inst, 32'd0);
        clrn = 1'b1;

        // Stream from reset with decode always ready.
        cycle(1'b1, 1'b0, 32'd0, 1'b1);
        chk("first_pc", id_pc, 32'h0000_0000);
        chk("first_inst", id_inst, 32'h1000_0000);
        cycle(1'b1, 1'b0, 32'd0, 1'b1);
        chk("second_pc", id_pc, 32'h0000_0004);
        chk("second_inst", id_inst, 32'h1400_0C21);
        repeat (3) cycle(1'b1, 1'b0, 32'd0, 1'b1);

        // Back-pressure: buffer saturates, then drains in order.
        redirect = 1'b1;
        redirect_pc = 32'd0;
        cycle(1'b1, 1'b1, 32'd0, 1'b0);
        repeat (6) cycle(1'b1, 1'b0, 32'd0, 1'b0);
        chk("stall_rom_a", rom_a, 32'h0000_0008);
        chk("stall_id_pc", id_pc, 32'h0000_0000);
        repeat (4) cycle(1'b1, 1'b0, 32'd0, 1'b1);

        // Redirect while full and ready: no pop, flush, realign target.
        repeat (3) cycle(1'b1, 1'b0, 32'd0, 1'b0);
        cycle(1'b1, 1'b1, 32'h0000_003E, 1'b1);
        chk("redir_valid", {31'd0, id_valid}, 32'd0);
        chk("redir_rom_a", rom_a, 32'h0000_003C);
        cycle(1'b1, 1'b0, 32'd0, 1'b1);
        chk("redir_id_pc", id_pc, 32'h0000_003C);

        // Drop fetch_en with the buffer full: drains, PC frozen.
        repeat (3) cycle(1'b1, 1'b0, 32'd0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 32'd0, 1'b1);
        chk("drain_valid", {31'd0, id_valid}, 32'd0);

        // Redirect in IDLE, then PC wrap at the top of the address space.
        cycle(1'b0, 1'b1, 32'hFFFF_FFFD, 1'b0);
        chk("wrap_rom_a0", rom_a, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 32'd0, 1'b1);
        chk("wrap_rom_a1", rom_a, 32'h0000_0000);
        chk("wrap_pc0", id_pc, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 32'd0, 1'b1);
        chk("wrap_pc1", id_pc, 32'h0000_0000);
        repeat (2) cycle(1'b1, 1'b0, 32'd0, 1'b0);

        // Short asynchronous reset pulse between clock edges.
        #2 clrn = 1'b0;
        #1;
        chk("arst_valid", {31'd0, id_valid}, 32'd0);
        chk("arst_rom_a", rom_a, 32'd0);
        #1 clrn = 1'b1;
        mq.delete();
        m_pc = '0;
        cycle(1'b1, 1'b0, 32'd0, 1'b1);
        chk("arst_restart", id_pc, 32'h0000_0000);
        repeat (2) cycle(1'b1, 1'b0, 32'd0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : 32'($urandom),
                  ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named as below.
REQ-002 The block SHALL have the following ports, one per line: name  direction  width  meaning.
- clk  in  1  rising-edge clock
- clrn  in  1  asynchronous active-low reset
- fetch_en  in  1  1 = fetching permitted
- redirect  in  1  branch/jump redirect strobe, one cycle
- redirect_pc  in  32  redirect target byte address
- rom_a  out  32  byte address to the instruction ROM (combinational ROM, index a[7:2])
- rom_inst  in  32  ROM word for rom_a, valid in the same cycle
- id_valid  out  1  buffer head valid to decode
- id_ready  in  1  decode accepts head
- id_inst  out  32  head instruction
- id_pc  out  32  head instruction byte address
REQ-003 The block SHALL have one parameter: DEPTH, default 2, prefetch buffer entries (2 or 4 only).

Function
REQ-004 The block SHALL hold a fetch PC register; rom_a SHALL equal the fetch PC, with bits [1:0] always 0.
REQ-005 The block SHALL implement a two-state FSM: IDLE and RUN; IDLE->RUN when fetch_en=1; RUN->IDLE when fetch_en=0; redirect SHALL NOT change state.
- The FSM SHALL be evaluated per cycle; fetch_en is sampled in the same cycle it takes effect.
REQ-006 The block SHALL implement a DEPTH-entry FIFO of {pc, inst} pairs with occupancy count 0..DEPTH.
REQ-007 In RUN, the block SHALL push {rom_a, rom_inst} at the clock edge, and PC SHALL advance by 4, when count<DEPTH, or when count==DEPTH and a pop occurs the same cycle.
REQ-008 In IDLE, the block SHALL perform no push and SHALL hold the PC; the buffer SHALL be retained and still presented to decode.
REQ-009 A pop SHALL occur when id_valid=1 and id_ready=1; the head SHALL advance at that edge.
REQ-010 id_valid SHALL be (count!=0); id_inst and id_pc SHALL be the head entry and SHALL be held stable while id_valid=1 and id_ready=0.
REQ-011 A simultaneous push and pop SHALL leave count unchanged.
REQ-012 Fetch latency: a word pushed at edge N SHALL be visible on id_* after edge N (zero added combinational path from rom_inst to id_inst).
REQ-013 Redirect SHALL have priority over push and pop in its cycle.
- At that edge: FIFO flushed (count=0); PC <= {redirect_pc[31:2],2'b00}; no push; any handshake that cycle discarded.
- The first post-redirect word SHALL be pushed the next cycle if in RUN.
REQ-014 PC arithmetic SHALL be 32-bit modulo; 0xFFFFFFFC+4 SHALL wrap to 0x00000000; ROM index wrap (64 words) is the ROM's concern.
REQ-015 Redirect in IDLE SHALL update the PC and flush the FIFO.
REQ-016 The block SHALL register no output combinationally from id_ready, except the pop decision.

Reset
REQ-017 While clrn=0, the block SHALL hold: FSM=IDLE, PC=0 (rom_a=0), count=0, id_valid=0, id_inst=0, id_pc=0.
REQ-018 Reset asserted mid-operation SHALL discard all buffered entries immediately (asynchronously).
REQ-019 After reset release with fetch_en=1, the first push SHALL be address 0x00 on the first rising edge.

Verification
REQ-020 The bench SHALL cover the following directed scenarios, using a ROM model with word[i] = 0x1000_0000+i, except word[1] = 0x14000C21.
- Reset release, fetch_en=1, id_ready=1 -> id_valid high after edge 1 with id_pc=0x00, id_inst=0x10000000; next cycle id_pc=0x04, id_inst=0x14000C21; then one entry per cycle.
- id_ready=0 for 6 cycles -> count saturates at DEPTH; rom_a stops at 0x08 (DEPTH=2); id_pc holds 0x00; after release, entries 0x00, 0x04, 0x08 arrive in order with none lost or duplicated.
- redirect=1, redirect_pc=0x0000003E, while buffer full and id_ready=1 -> no pop counted; id_valid=0 next cycle; PC=0x3C; next id_pc=0x3C.
- fetch_en dropped with 2 entries buffered -> both drain to decode; rom_a stays constant; id_valid then 0.
- PC at 0xFFFFFFFC in RUN -> next rom_a=0x00000000; id_pc sequence 0xFFFFFFFC, 0x00000000.
- clrn pulsed low mid-stream for under a clock period -> id_valid=0 and rom_a=0 immediately; fetch restarts at 0x00.
